// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// Purpose : shared constants and helpers for the write-side FIFO pointer controller.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package fifo_wr_ptr_ctrl_pkg;

    // Width of the generic argument taken by fifo_full_pattern().
    localparam int unsigned GRAY_FN_WIDTH = 32;

    // Pointers carry one extra wrap bit beyond the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_util.svh
// Purpose : Gray/binary converters and the full-compare pattern shared by both FIFO pointer controllers.
// Latency : purely combinational.
// Backpressure: n/a.
`ifndef FIFO_UTIL_SVH
`define FIFO_UTIL_SVH

// Full when the write pointer equals the read pointer with its top two Gray
// bits inverted (one lap ahead). Operates on a 32-bit container; callers
// zero-extend their pointer and truncate the result back to pointer width.
function automatic logic [31:0] fifo_full_pattern(input logic [31:0] gray,
                                                  input int unsigned width);
    return gray ^ (32'd3 << (width - 2));
endfunction

// Binary to Gray.
module b2g_converter #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
module g2b_converter #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

`endif

// File: rtl/gray_ptr_sync.sv
// Purpose : multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency : STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports   : clk, reset (async active-high), d (async Gray input), q (synchronised Gray output).
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Purpose : write-side pointer/flag controller of a dual-clock FIFO; drives the RAM write port,
//           publishes a registered Gray write pointer and derives full/almost_full/level.
// Latency : push -> wr_ptr_gray/full/level on the push edge; read-pointer change -> flags after SYNC_STAGES+1 edges.
// Backpressure: wr_ready drops while full or in reset; full is pessimistic and never early.
// Ports   : clk, reset, wr_valid/wr_ready, ram_we/ram_waddr, rd_ptr_gray_async in,
//           wr_ptr_gray, full, almost_full, level out.
`include "fifo_util.svh"

module fifo_wr_ptr_ctrl
    import fifo_wr_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH        = 4,
    parameter int ALMOST_FULL_LEVEL = 12,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

    generate
        if (ADDR_WIDTH < 2) begin : g_bad_addr_width
            $error("fifo_wr_ptr_ctrl: ADDR_WIDTH must be >= 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("fifo_wr_ptr_ctrl: SYNC_STAGES must be >= 2");
        end
        if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > (1 << ADDR_WIDTH)) begin : g_bad_af_level
            $error("fifo_wr_ptr_ctrl: ALMOST_FULL_LEVEL out of range");
        end
    endgenerate

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_bin_next;
    logic [PW-1:0] wr_gray_next;
    logic [PW-1:0] rd_gray_s;
    logic [PW-1:0] rd_bin_s;
    logic [PW-1:0] full_pat;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          push;

    // Holding ready low during reset discards any push in flight.
    assign wr_ready  = ~full & ~reset;
    assign push      = wr_valid & wr_ready;
    assign ram_we    = push;
    assign ram_waddr = wr_bin[ADDR_WIDTH-1:0];

    assign wr_bin_next = wr_bin + PW'(push);

    b2g_converter #(.WIDTH(PW)) u_wr_b2g (
        .bin  (wr_bin_next),
        .gray (wr_gray_next)
    );

    gray_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rd_ptr_gray_async),
        .q     (rd_gray_s)
    );

    g2b_converter #(.WIDTH(PW)) u_rd_g2b (
        .gray (rd_gray_s),
        .bin  (rd_bin_s)
    );

    // Push and a read-pointer advance seen in the same cycle both feed this
    // single next-state computation, so full and level never disagree.
    assign full_pat   = PW'(fifo_full_pattern(GRAY_FN_WIDTH'(rd_gray_s), PW));
    assign full_next  = (wr_gray_next == full_pat);
    assign level_next = wr_bin_next - rd_bin_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
        end else begin
            wr_bin      <= wr_bin_next;
            wr_ptr_gray <= wr_gray_next;
            full        <= full_next;
            almost_full <= (level_next >= AF_LEVEL);
            level       <= level_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Purpose : directed self-checking bench for fifo_wr_ptr_ctrl (ADDR_WIDTH=4, ALMOST_FULL_LEVEL=12, SYNC_STAGES=2).
// Latency : n/a.
// Backpressure: n/a.
module tb_fifo_wr_ptr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [4:0] rd_ptr_gray_async;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] level;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_wr_ptr_ctrl #(
        .ADDR_WIDTH        (4),
        .ALMOST_FULL_LEVEL (12),
        .SYNC_STAGES       (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .ram_we            (ram_we),
        .ram_waddr         (ram_waddr),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .wr_ptr_gray       (wr_ptr_gray),
        .full              (full),
        .almost_full       (almost_full),
        .level             (level)
    );

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_valid = 1'b0; rd_ptr_gray_async = 5'b0;
        tick(3);
        vectors++; if (wr_ptr_gray !== 5'b0) begin miscompares++; $display("FAIL reset_gray got=%b exp=00000", wr_ptr_gray); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level got=%0d exp=0", level); end
        vectors++; if (full !== 1'b0 || almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_flags got full=%b af=%b exp 0 0", full, almost_full); end
        vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
        reset = 1'b0;
        wr_valid = 1'b1;
        tick(5);
        vectors++; if (wr_ptr_gray !== 5'b00111) begin miscompares++; $display("FAIL pre_reset_gray got=%b exp=00111", wr_ptr_gray); end
        vectors++; if (level !== 5'd5) begin miscompares++; $display("FAIL pre_reset_level got=%0d exp=5", level); end
        // Reset asserted mid-cycle with a push still requested.
        #2 reset = 1'b1;
        #1;
        vectors++; if (wr_ptr_gray !== 5'b0) begin miscompares++; $display("FAIL midreset_gray got=%b exp=00000", wr_ptr_gray); end
        vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL midreset_level got=%0d exp=0", level); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL midreset_full got=%b exp=0", full); end
        vectors++; if (wr_ready !== 1'b0 || ram_we !== 1'b0) begin miscompares++; $display("FAIL midreset_ready got rdy=%b we=%b exp 0 0", wr_ready, ram_we); end
        tick(1);
        wr_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready got=%b exp=1", wr_ready); end
        tick(1);
        vectors++; if (wr_ptr_gray !== 5'b0) begin miscompares++; $display("FAIL release_gray got=%b exp=00000", wr_ptr_gray); end
    endtask

    task automatic test_fill;
        logic [3:0] exp_addr;
        rd_ptr_gray_async = 5'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            exp_addr = i[3:0];
            #1;
            vectors++; if (ram_we !== 1'b1 || ram_waddr !== exp_addr) begin miscompares++; $display("FAIL fill_addr push=%0d got we=%b addr=%0d exp we=1 addr=%0d", i, ram_we, ram_waddr, exp_addr); end
            tick(1);
            vectors++; if (level !== 5'(i + 1)) begin miscompares++; $display("FAIL fill_level push=%0d got=%0d exp=%0d", i, level, i + 1); end
            vectors++; if (almost_full !== (i + 1 >= 12)) begin miscompares++; $display("FAIL fill_af push=%0d got=%b exp=%b", i, almost_full, (i + 1 >= 12)); end
            vectors++; if (full !== (i == 15)) begin miscompares++; $display("FAIL fill_full push=%0d got=%b exp=%b", i, full, (i == 15)); end
            vectors++; if (wr_ptr_gray !== gray5(i + 1)) begin miscompares++; $display("FAIL fill_gray push=%0d got=%b exp=%b", i, wr_ptr_gray, gray5(i + 1)); end
        end
        vectors++; if (wr_ptr_gray !== 5'b11000) begin miscompares++; $display("FAIL full_gray got=%b exp=11000", wr_ptr_gray); end
    endtask

    task automatic test_push_while_full;
        wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++; if (ram_we !== 1'b0 || wr_ready !== 1'b0) begin miscompares++; $display("FAIL blocked_we cyc=%0d got we=%b rdy=%b exp 0 0", i, ram_we, wr_ready); end
            tick(1);
            vectors++; if (wr_ptr_gray !== 5'b11000 || level !== 5'd16 || full !== 1'b1) begin miscompares++; $display("FAIL blocked_state cyc=%0d got gray=%b lvl=%0d full=%b exp 11000 16 1", i, wr_ptr_gray, level, full); end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_free_slots;
        rd_ptr_gray_async = 5'b00001;   // read pointer 1, driven just after edge N
        tick(1);
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL free_n1_full got=%b exp=1", full); end
        tick(1);
        vectors++; if (full !== 1'b1 || level !== 5'd16) begin miscompares++; $display("FAIL free_n2 got full=%b lvl=%0d exp 1 16", full, level); end
        tick(1);
        vectors++; if (full !== 1'b0 || level !== 5'd15 || almost_full !== 1'b1) begin miscompares++; $display("FAIL free_n3 got full=%b lvl=%0d af=%b exp 0 15 1", full, level, almost_full); end
        rd_ptr_gray_async = 5'b00110;   // 4
        tick(3);
        vectors++; if (level !== 5'd12 || almost_full !== 1'b1) begin miscompares++; $display("FAIL free_rd4 got lvl=%0d af=%b exp 12 1", level, almost_full); end
        rd_ptr_gray_async = 5'b00111;   // 5
        tick(3);
        vectors++; if (level !== 5'd11 || almost_full !== 1'b0) begin miscompares++; $display("FAIL free_rd5 got lvl=%0d af=%b exp 11 0", level, almost_full); end
    endtask

    // Writer at 16, reader at 5: the reader drains to 3 behind, then both
    // advance together while the writer completes 40 pushes and wraps.
    task automatic test_wrap;
        int wb, rb, pushes, idle, c;
        int hist [0:299];
        int exp_level;
        logic do_push, adv;
        logic [4:0] prev_gray;
        logic [3:0] exp_addr;
        bit saw_wrap;
        wb = 16; rb = 5; pushes = 0; idle = 0; c = 0; saw_wrap = 1'b0;
        hist[0] = 5; hist[1] = 5;
        prev_gray = wr_ptr_gray;
        while ((pushes < 40 || idle < 4) && c < 290) begin
            do_push = (pushes < 40) && (wb - rb <= 3);
            adv     = (wb - rb > 3);
            if (adv) rb++;
            hist[c + 2] = rb;
            rd_ptr_gray_async = gray5(rb);
            wr_valid = do_push;
            if (do_push) begin
                exp_addr = 4'(wb % 16);
                #1;
                vectors++; if (ram_we !== 1'b1 || ram_waddr !== exp_addr) begin miscompares++; $display("FAIL wrap_addr cyc=%0d got we=%b addr=%0d exp we=1 addr=%0d", c, ram_we, ram_waddr, exp_addr); end
            end
            tick(1);
            if (do_push) begin wb++; pushes++; end
            if (pushes >= 40) idle++;
            exp_level = wb - hist[c];
            vectors++; if (level !== 5'(exp_level)) begin miscompares++; $display("FAIL wrap_level cyc=%0d got=%0d exp=%0d", c, level, exp_level); end
            vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL wrap_false_full cyc=%0d got=%b exp=0", c, full); end
            vectors++; if (wr_ptr_gray !== gray5(wb)) begin miscompares++; $display("FAIL wrap_gray cyc=%0d got=%b exp=%b", c, wr_ptr_gray, gray5(wb)); end
            vectors++; if ($countones(wr_ptr_gray ^ prev_gray) !== (do_push ? 1 : 0)) begin miscompares++; $display("FAIL wrap_hamming cyc=%0d got=%0d exp=%0d", c, $countones(wr_ptr_gray ^ prev_gray), do_push ? 1 : 0); end
            if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) saw_wrap = 1'b1;
            prev_gray = wr_ptr_gray;
            c++;
        end
        wr_valid = 1'b0;
        vectors++; if (saw_wrap !== 1'b1) begin miscompares++; $display("FAIL wrap_seen got=%b exp=1", saw_wrap); end
        vectors++; if (wr_ptr_gray !== 5'b10100) begin miscompares++; $display("FAIL wrap_final_gray got=%b exp=10100", wr_ptr_gray); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_push_while_full();
        test_free_slots();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
- Write-side pointer and flag controller for the MPEG-path dual-clock FIFOs. Runs entirely in the write clock domain.
- Accepts pushes through a valid/ready handshake and drives the RAM write port.
- Publishes a registered Gray-coded write pointer to the read domain.
- Synchronises the read domain's Gray pointer and derives full, almost_full and fill level from it.

Parameters:
- ADDR_WIDTH, 4: log2 of FIFO depth. Pointers are ADDR_WIDTH+1 bits.
- ALMOST_FULL_LEVEL, 12: level at or above which almost_full asserts. Legal range 1..2**ADDR_WIDTH.
- SYNC_STAGES, 2: flop stages on the incoming read pointer. Minimum 2.

Ports:
- clk  in  1  write-domain clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  push request.
- wr_ready  out  1  push accepted this cycle when high together with wr_valid.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- rd_ptr_gray_async  in  ADDR_WIDTH+1  Gray read pointer, launched from the read domain's register.
- wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- full  out  1  FIFO full.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- level  out  ADDR_WIDTH+1  occupied entries as seen by the write side, range 0..2**ADDR_WIDTH.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: wr_bin = 0, wr_ptr_gray = 0, all sync stages = 0, full = 0, almost_full = 0, level = 0, ram_we = 0.
- wr_ready = ~full & ~reset, so wr_ready is 0 while reset is asserted.
- push = wr_valid & wr_ready.
- ram_we = push, combinational.
- ram_waddr = wr_bin[ADDR_WIDTH-1:0], combinational. Data is written at the push edge.
- wr_bin_next = wr_bin + push, modulo 2**(ADDR_WIDTH+1). The MSB toggles on each wrap.
- wr_ptr_gray is registered from b2g(wr_bin_next), so the output is glitch-free and changes by exactly one bit per push.
- Read-pointer synchroniser: a SYNC_STAGES-deep flop chain on rd_ptr_gray_async produces rd_gray_s.
- rd_bin_s = g2b(rd_gray_s), combinational.
- full register: next value = (b2g(wr_bin_next) == {~rd_gray_s[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray_s[ADDR_WIDTH-2:0]}).
  - Asserts on the same edge as the push that fills the FIFO.
- level register: next value = wr_bin_next - rd_bin_s, modulo 2**(ADDR_WIDTH+1).
- almost_full register: next value = (level_next >= ALMOST_FULL_LEVEL).
- Latency, read frees space: a read-pointer change at edge N shows up in full, level and almost_full at edge N+SYNC_STAGES+1. full is pessimistic and never early.
- Push while full: cannot occur (wr_ready = 0). RAM and pointer do not change.
- Push on the cycle the synced read pointer advances: both effects are applied in the same next-state computation, so flags remain consistent.
- Reset mid-operation: all state clears immediately, and any in-flight push is discarded. The read side must be reset concurrently; that is a system requirement.
- Elaboration errors: ADDR_WIDTH < 2, SYNC_STAGES < 2, or ALMOST_FULL_LEVEL out of range.

Decomposition:
- Shared header (guarded util .svh):
  - Existing b2g_converter and g2b_converter, instantiated here.
  - New function fifo_full_pattern(gray), which inverts the top two bits. The read-side controller reuses it.
- One sub-module: gray_ptr_sync
  - Parameters WIDTH and STAGES; ports clk, reset, d, q.
  - Async-reset flop chain with ASYNC_REG attributes.
  - Shared with the read-side controller.

Test Plan (ADDR_WIDTH=4, ALMOST_FULL_LEVEL=12, SYNC_STAGES=2):
- Reset: assert reset after 5 pushes.
  - During reset: wr_ptr_gray = 0, level = 0, full = 0, wr_ready = 0.
  - After release: wr_ready = 1.
- Fill: 16 back-to-back pushes with rd pointer 0.
  - ram_waddr steps 0..15.
  - almost_full rises on the 12th push edge.
  - full and level = 16 on the 16th push edge.
  - wr_ptr_gray = 5'b11000.
- Push while full: hold wr_valid for 10 cycles.
  - ram_we stays 0; wr_ptr_gray, level and full are unchanged.
- Free one slot: drive rd_ptr_gray_async = 5'b00001 at edge N.
  - full falls at edge N+3 with level 15; almost_full stays 1.
- Free further slots:
  - rd gray for 4 (5'b00110): level = 12, almost_full = 1.
  - rd gray for 5 (5'b00111): level = 11, almost_full = 0.
- Wrap: 40 pushes with a model reader trailing by 3 entries.
  - Each wr_ptr_gray update has Hamming distance 1.
  - Pointer wraps 31 -> 0 (gray 10000 -> 00000).
  - No false full.
  - level never exceeds 16 and matches the scoreboard.
